stack_pop_unit: RTL



---
 rtl/stack_pop_unit_pkg.sv | 29 ++
 rtl/stack_pop_unit.sv | 131 +++++++++++++
 2 files changed

// File: rtl/stack_pop_unit_pkg.sv
// stack_pop_unit_pkg
// Shared definitions for the stack pop sequencer: FSM state encoding,
// default widths, condition-code bit positions inside a popped flags byte,
// and the data-memory read latency the sequencer is built around.
package stack_pop_unit_pkg;

    localparam int DW_DEF = 8;   // data / address width
    localparam int FW_DEF = 4;   // condition-code width

    // Bit positions of the flags inside the popped byte.
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    // Read data returns one cycle after the strobe; each pop is therefore
    // an ADDR cycle followed by a DATA cycle.
    localparam int MEM_RD_LAT = 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FL_ADDR = 3'd1,
        ST_FL_DATA = 3'd2,
        ST_PC_ADDR = 3'd3,
        ST_PC_DATA = 3'd4,
        ST_DONE    = 3'd5
    } pop_state_t;

endpackage

// File: rtl/stack_pop_unit.sv
// stack_pop_unit
// Pops the return state off the stack for RET (PC only) and RTI (flags,
// then PC), mirroring the push order used on CALL / interrupt entry.
// Each byte is one read: pre-increment SP, read M[SP], then publish SP.
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | waiting for a decoded RET / RTI pulse
// FL_ADDR  | read strobe for flags byte at SP+1
// FL_DATA  | flags byte on mem_rdata: load CCR, publish SP
// PC_ADDR  | read strobe for PC byte at SP+1
// PC_DATA  | PC byte on mem_rdata: load PC, publish SP
// DONE     | sequence complete pulse, back to IDLE
//
// Ports:
//   clk, rst              clock, async active-low reset
//   start_ret, start_rti  one-cycle decode pulses (RTI wins if both)
//   sp_in                 architectural SP captured at start
//   mem_rdata             stack read data, one cycle after mem_rd_en
//   mem_rd_en, mem_addr   stack read request
//   sp_wr_en, sp_next     SP update, once per popped byte
//   pc_load, pc_value     restored PC
//   flags_load, flags_value restored condition codes
//   stall, int_mask       pipeline freeze / interrupt block while busy
//   done                  one-cycle completion pulse
module stack_pop_unit
    import stack_pop_unit_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int FW = FW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_ret,
    input  logic          start_rti,
    input  logic [DW-1:0] sp_in,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_rd_en,
    output logic [DW-1:0] mem_addr,
    output logic          sp_wr_en,
    output logic [DW-1:0] sp_next,
    output logic          pc_load,
    output logic [DW-1:0] pc_value,
    output logic          flags_load,
    output logic [FW-1:0] flags_value,
    output logic          stall,
    output logic          int_mask,
    output logic          done
);

    pop_state_t    state_q, state_d;
    logic [DW-1:0] sp_q, sp_d;
    logic [DW-1:0] sp_inc;

    // Wraps mod 2^DW by construction.
    assign sp_inc = sp_q + {{(DW-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            sp_q    <= '0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        mem_rd_en   = 1'b0;
        mem_addr    = '0;
        sp_wr_en    = 1'b0;
        sp_next     = '0;
        pc_load     = 1'b0;
        pc_value    = '0;
        flags_load  = 1'b0;
        flags_value = '0;
        done        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_rti) begin
                    state_d = ST_FL_ADDR;
                    sp_d    = sp_in;
                end else if (start_ret) begin
                    state_d = ST_PC_ADDR;
                    sp_d    = sp_in;
                end
            end
            ST_FL_ADDR: begin
                mem_rd_en = 1'b1;
                mem_addr  = sp_inc;
                sp_d      = sp_inc;
                state_d   = ST_FL_DATA;
            end
            ST_FL_DATA: begin
                flags_load  = 1'b1;
                flags_value = mem_rdata[FW-1:0];
                sp_wr_en    = 1'b1;
                sp_next     = sp_q;
                state_d     = ST_PC_ADDR;
            end
            ST_PC_ADDR: begin
                mem_rd_en = 1'b1;
                mem_addr  = sp_inc;
                sp_d      = sp_inc;
                state_d   = ST_PC_DATA;
            end
            ST_PC_DATA: begin
                pc_load  = 1'b1;
                pc_value = mem_rdata;
                sp_wr_en = 1'b1;
                sp_next  = sp_q;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Stall combinationally on the start pulse so decode freezes in cycle 0.
    assign stall    = (state_q != ST_IDLE) | start_ret | start_rti;
    assign int_mask = stall;

endmodule
